// File: rtl/serial_cmd_parser.sv
// serial_cmd_parser: MCU byte-packet decoder driving config-register reads/writes.
// Define CMD_CHECKSUM_EN to require and acknowledge a checksum byte on WRITE.
module serial_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TX_HOLD        = 8,
    parameter int TX_GAP         = 64
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic [7:0] rx_data_4x,
    input  logic       rx_new_data_4x,
    output logic [7:0] tx_data_4x,
    output logic       tx_new_data_4x,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    output logic       cfg_we,
    input  logic [7:0] cfg_rdata,
    output logic [7:0] err_count
);

    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW  = $clog2(TX_HOLD + 1);
    localparam int GW  = $clog2(TX_GAP + 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h50;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef CMD_CHECKSUM_EN
        GET_CSUM,
`endif
        DO_WRITE,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t         state;
    logic           rx_prev;
    logic           skid_full;
    logic [7:0]     skid_data;
    logic           is_write;
    logic [7:0]     tx_byte;
    logic [TOW-1:0] to_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [GW-1:0]  gap_cnt;

    logic rx_edge, in_get, pop, drop;
    logic timeout_hit, bad_op, csum_bad, err_evt;

    // Intake handshake, timeout detect and error event merge.
    always_comb begin
        rx_edge = rx_new_data_4x & ~rx_prev;
        in_get  = (state == GET_ADDR) || (state == GET_DATA);
`ifdef CMD_CHECKSUM_EN
        in_get  = in_get || (state == GET_CSUM);
`endif
        pop  = skid_full && ((state == IDLE) || in_get);
        drop = rx_edge && skid_full && !pop;
        timeout_hit = in_get && !pop
                    && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
        bad_op = pop && (state == IDLE)
               && !(skid_data inside {OP_WRITE, OP_READ, OP_PING});
        csum_bad = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_bad = pop && (state == GET_CSUM)
                 && (skid_data != (OP_WRITE ^ cfg_addr ^ cfg_wdata));
`endif
        err_evt = drop | bad_op | timeout_hit | csum_bad;
    end

    // Strobe edge detect and one-entry skid buffer.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev   <= 1'b0;
            skid_full <= 1'b0;
            skid_data <= 8'h00;
        end else begin
            rx_prev <= rx_new_data_4x;
            if (rx_edge && (!skid_full || pop)) begin
                skid_full <= 1'b1;
                skid_data <= rx_data_4x;
            end else if (pop) begin
                skid_full <= 1'b0;
            end
        end
    end

    // Saturating error counter; simultaneous events count once.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'h00;
        end else if (err_evt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end

    // Packet FSM with reply pulse/gap timers and inter-byte timeout.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            is_write       <= 1'b0;
            tx_byte        <= 8'h00;
            tx_data_4x     <= 8'h00;
            tx_new_data_4x <= 1'b0;
            cfg_addr       <= 8'h00;
            cfg_wdata      <= 8'h00;
            cfg_we         <= 1'b0;
            to_cnt         <= '0;
            hold_cnt       <= '0;
            gap_cnt        <= '0;
        end else begin
            cfg_we <= 1'b0;

            if (tx_new_data_4x) begin
                if (hold_cnt == '0) begin
                    tx_new_data_4x <= 1'b0;
                    gap_cnt        <= GW'(TX_GAP);
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (in_get && !pop) to_cnt <= to_cnt + 1'b1;
            else                to_cnt <= '0;

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        unique case (1'b1)
                            (skid_data == OP_WRITE): begin
                                is_write <= 1'b1;
                                state    <= GET_ADDR;
                            end
                            (skid_data == OP_READ): begin
                                is_write <= 1'b0;
                                state    <= GET_ADDR;
                            end
                            (skid_data == OP_PING): begin
                                tx_byte <= 8'h4B;
                                state   <= TX_SEND;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                GET_ADDR: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (pop) begin
                        cfg_addr <= skid_data;
                        state    <= is_write ? GET_DATA : RD_WAIT;
                    end
                end
                GET_DATA: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (pop) begin
                        cfg_wdata <= skid_data;
`ifdef CMD_CHECKSUM_EN
                        state     <= GET_CSUM;
`else
                        cfg_we    <= 1'b1;
                        state     <= DO_WRITE;
`endif
                    end
                end
`ifdef CMD_CHECKSUM_EN
                GET_CSUM: begin
                    if (timeout_hit) begin
                        state <= IDLE;
                    end else if (pop) begin
                        if (csum_bad) begin
                            tx_byte <= 8'h15;
                            state   <= TX_SEND;
                        end else begin
                            cfg_we  <= 1'b1;
                            tx_byte <= 8'h06;
                            state   <= DO_WRITE;
                        end
                    end
                end
                DO_WRITE: state <= TX_SEND;
`else
                DO_WRITE: state <= IDLE;
`endif
                RD_WAIT: begin
                    tx_byte <= cfg_rdata;
                    state   <= TX_SEND;
                end
                TX_SEND: begin
                    if (!tx_new_data_4x && (gap_cnt == '0)) begin
                        tx_new_data_4x <= 1'b1;
                        hold_cnt       <= HW'(TX_HOLD - 1);
                        tx_data_4x     <= tx_byte;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
